// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the dual-rail 7-segment decoder.
package seg7_pkg;

    typedef struct packed {
        logic t;
        logic f;
    } dr_bit_t;

    typedef enum logic {PH_NULL, PH_DATA} phase_e;

    // Index 15 sits in the top slice, so the list reads F down to 0 (segment order g..a).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/segment7_dual_rail_if.sv
// Dual-rail value in, dual-rail segments out; the decoder is the slave side.
interface segment7_dual_rail_if;

    logic [3:0] bcd_t;
    logic [3:0] bcd_f;
    logic [6:0] seg_t;
    logic [6:0] seg_f;
    logic       complete;
    logic       err;

    modport master (output bcd_t, bcd_f, input seg_t, seg_f, complete, err);
    modport slave  (input bcd_t, bcd_f, output seg_t, seg_f, complete, err);

endinterface

// File: rtl/segment7_dual_rail_ncl_completion.sv
// Combinational completion detection over W dual-rail bits.
module ncl_completion
    import seg7_pkg::*;
#(
    parameter int W = 4
) (
    input  dr_bit_t [W-1:0] bits,
    output logic            all_data,
    output logic            all_null,
    output logic            any_illegal
);

    logic [W-1:0] t;
    logic [W-1:0] f;

    always_comb begin
        for (int i = 0; i < W; i++) begin
            t[i] = bits[i].t;
            f[i] = bits[i].f;
        end
    end

    // A bit is DATA only when exactly one rail is high, so ILLEGAL bits never count as DATA.
    assign all_data    = &(t ^ f);
    assign all_null    = ~|(t | f);
    assign any_illegal = |(t & f);

endmodule

// File: rtl/segment7_dual_rail.sv
// Dual-rail hex-to-7-segment decoder with NCL hysteresis held in a clocked phase flop.
module segment7_dual_rail
    import seg7_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    segment7_dual_rail_if.slave         bus
);

    dr_bit_t [3:0] in_bits;
    logic          all_data;
    logic          all_null;
    logic          any_illegal;

    phase_e     phase, phase_next;
    logic [6:0] seg_t_q, seg_t_next;
    logic [6:0] seg_f_q, seg_f_next;
    logic       err_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_bits[i].t = bus.bcd_t[i];
            in_bits[i].f = bus.bcd_f[i];
        end
    end

    ncl_completion #(.W(4)) u_in_completion (
        .bits        (in_bits),
        .all_data    (all_data),
        .all_null    (all_null),
        .any_illegal (any_illegal)
    );

    // NOTE: defaults first so every path assigns every output; no latches can be inferred.
    always_comb begin
        phase_next = phase;
        seg_t_next = seg_t_q;
        seg_f_next = seg_f_q;
        unique case (phase)
            PH_NULL: begin
                if (all_data && !any_illegal) begin
                    phase_next = PH_DATA;
                    seg_t_next = hex_to_seg(bus.bcd_t);
                    seg_f_next = ~hex_to_seg(bus.bcd_t);
                end
            end
            PH_DATA: begin
                if (all_null) begin
                    phase_next = PH_NULL;
                    seg_t_next = '0;
                    seg_f_next = '0;
                end
            end
            default: phase_next = PH_NULL;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= PH_NULL;
            seg_t_q <= '0;
            seg_f_q <= '0;
            err_q   <= 1'b0;
        end else begin
            phase   <= phase_next;
            seg_t_q <= seg_t_next;
            seg_f_q <= seg_f_next;
            err_q   <= any_illegal;
        end
    end

    assign bus.seg_t    = seg_t_q;
    assign bus.seg_f    = seg_f_q;
    assign bus.complete = (phase == PH_DATA);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_segment7_dual_rail.sv
// Directed self-checking bench for the dual-rail 7-segment decoder.
module tb_segment7_dual_rail;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    segment7_dual_rail_if bus ();

    segment7_dual_rail dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed word: seg_t, seg_f, complete, err.
    logic [15:0] obs;
    assign obs = {bus.seg_t, bus.seg_f, bus.complete, bus.err};

    logic [6:0] exp_seg [16];
    initial begin
        exp_seg[0]  = 7'h3F; exp_seg[1]  = 7'h06; exp_seg[2]  = 7'h5B; exp_seg[3]  = 7'h4F;
        exp_seg[4]  = 7'h66; exp_seg[5]  = 7'h6D; exp_seg[6]  = 7'h7D; exp_seg[7]  = 7'h07;
        exp_seg[8]  = 7'h7F; exp_seg[9]  = 7'h6F; exp_seg[10] = 7'h77; exp_seg[11] = 7'h7C;
        exp_seg[12] = 7'h39; exp_seg[13] = 7'h5E; exp_seg[14] = 7'h79; exp_seg[15] = 7'h71;
    end

    function automatic logic [15:0] dat(input logic [6:0] s, input logic e);
        return {s, ~s, 1'b1, e};
    endfunction

    task automatic drive(input logic [3:0] t, input logic [3:0] f);
        bus.bcd_t = t;
        bus.bcd_f = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(4'h5, 4'hA);
        repeat (3) step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL reset_hold: got %h expected %h", obs, 16'h0); errors++;
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL reset_release_no_edge: got %h expected %h", obs, 16'h0); errors++;
        end
        step();
        checks++;
        if (obs !== dat(7'h6D, 1'b0)) begin
            $display("FAIL reset_release_data: got %h expected %h", obs, dat(7'h6D, 1'b0)); errors++;
        end
        drive(4'h0, 4'h0);
        step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL reset_then_null: got %h expected %h", obs, 16'h0); errors++;
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            drive(4'h0, 4'h0);
            step();
            checks++;
            if (obs !== 16'h0) begin
                $display("FAIL sweep_null[%0d]: got %h expected %h", i, obs, 16'h0); errors++;
            end
            drive(v, ~v);
            step();
            checks++;
            if (obs !== dat(exp_seg[i], 1'b0)) begin
                $display("FAIL sweep_data[%0d]: got %h expected %h", i, obs, dat(exp_seg[i], 1'b0)); errors++;
            end
        end
        drive(4'h0, 4'h0);
        step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL sweep_final_null: got %h expected %h", obs, 16'h0); errors++;
        end
    endtask

    task automatic test_partial();
        drive(4'b0001, 4'b0100);
        step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL partial_hold_null: got %h expected %h", obs, 16'h0); errors++;
        end
        drive(4'b0001, 4'b1110);
        step();
        checks++;
        if (obs !== dat(7'h06, 1'b0)) begin
            $display("FAIL partial_complete: got %h expected %h", obs, dat(7'h06, 1'b0)); errors++;
        end
        drive(4'h0, 4'h0);
        step();
    endtask

    task automatic test_hysteresis();
        drive(4'h8, 4'h7);
        step();
        checks++;
        if (obs !== dat(7'h7F, 1'b0)) begin
            $display("FAIL hyst_load8: got %h expected %h", obs, dat(7'h7F, 1'b0)); errors++;
        end
        drive(4'h0, 4'b0011);
        step();
        checks++;
        if (obs !== dat(7'h7F, 1'b0)) begin
            $display("FAIL hyst_partial_null: got %h expected %h", obs, dat(7'h7F, 1'b0)); errors++;
        end
        drive(4'h3, 4'hC);
        step();
        checks++;
        if (obs !== dat(7'h7F, 1'b0)) begin
            $display("FAIL hyst_frozen: got %h expected %h", obs, dat(7'h7F, 1'b0)); errors++;
        end
        drive(4'h0, 4'h0);
        step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL hyst_release: got %h expected %h", obs, 16'h0); errors++;
        end
    endtask

    task automatic test_illegal();
        drive(4'hF, 4'h1);
        step();
        checks++;
        if (obs !== 16'h0001) begin
            $display("FAIL illegal_from_null: got %h expected %h", obs, 16'h0001); errors++;
        end
        drive(4'h0, 4'h0);
        step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL illegal_clear: got %h expected %h", obs, 16'h0); errors++;
        end
        drive(4'h4, 4'hB);
        step();
        drive(4'hF, 4'h1);
        step();
        checks++;
        if (obs !== dat(7'h66, 1'b1)) begin
            $display("FAIL illegal_in_data: got %h expected %h", obs, dat(7'h66, 1'b1)); errors++;
        end
        drive(4'h0, 4'h0);
        step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL illegal_to_null: got %h expected %h", obs, 16'h0); errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [3];
        vals[0] = 4'h9; vals[1] = 4'hA; vals[2] = 4'hB;
        for (int k = 0; k < 3; k++) begin
            drive(vals[k], ~vals[k]);
            step();
            checks++;
            if (obs !== dat(exp_seg[vals[k]], 1'b0)) begin
                $display("FAIL b2b_data[%0d]: got %h expected %h", k, obs, dat(exp_seg[vals[k]], 1'b0)); errors++;
            end
            drive(4'h0, 4'h0);
            step();
            checks++;
            if (obs !== 16'h0) begin
                $display("FAIL b2b_null[%0d]: got %h expected %h", k, obs, 16'h0); errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        drive(4'hE, 4'h1);
        step();
        checks++;
        if (obs !== dat(7'h79, 1'b0)) begin
            $display("FAIL async_load_e: got %h expected %h", obs, dat(7'h79, 1'b0)); errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL async_reset_immediate: got %h expected %h", obs, 16'h0); errors++;
        end
        drive(4'h0, 4'h0);
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== 16'h0) begin
            $display("FAIL async_after_release: got %h expected %h", obs, 16'h0); errors++;
        end
    endtask

    initial begin
        drive(4'h0, 4'h0);
        test_reset();
        test_sweep();
        test_partial();
        test_hysteresis();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
